multicycle_seq: RTL and testbench

Multi-cycle instruction sequencer for the RV32I core: a parametrised successor to the single-cycle top. It replaces the one-instruction-per-clock flow with a FETCH/DECODE/EXEC/MEM/WB state machine. Memory and IO are reached through a req/ack handshake, so BRAM or slow peripherals can insert wait states. It also adds halt, single-step and retirement/cycle counters for board-level debugging from buttons. It drives datapath enables only; the datapath, ALU and register file are external.

---
 rtl/multicycle_seq_if.sv | 38 +++
 rtl/multicycle_seq.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_seq_if.sv
// multicycle_seq_if: control/debug bundle between the RV32I sequencer and its datapath/memory side.
// Rev 1.0
`default_nettype none
interface multicycle_seq_if #(
  parameter int CNT_W = 32
);
  logic             run_en;
  logic             step;
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             mem_ack;
  logic             mem_req;
  logic             mem_we;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             rf_we;
  logic [1:0]       wb_sel;
  logic             halted;
  logic             illegal;
  logic             bus_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  run_en, step, opcode, branch_taken, mem_ack,
    output mem_req, mem_we, ir_we, pc_we, pc_src, rf_we, wb_sel,
    output halted, illegal, bus_err, state, cycle_cnt, instret_cnt
  );

  modport slave (
    output run_en, step, opcode, branch_taken, mem_ack,
    input  mem_req, mem_we, ir_we, pc_we, pc_src, rf_we, wb_sel,
    input  halted, illegal, bus_err, state, cycle_cnt, instret_cnt
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_seq.sv
// multicycle_seq: FETCH/DECODE/EXEC/MEM/WB sequencer for RV32I with req/ack memory, halt/step and counters.
// Rev 1.0
`default_nettype none
module multicycle_seq #(
  parameter int CNT_W        = 32,
  parameter int TIMEOUT      = 255,
  parameter bit START_HALTED = 1'b0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  multicycle_seq_if.master bus
);
  typedef enum logic [2:0] {
    HALT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam state_t     RESET_STATE = START_HALTED ? HALT : FETCH;

  state_t           state, state_nx;
  logic             oneshot, oneshot_nx;
  logic             illegal, illegal_nx;
  logic             bus_err, bus_err_nx;
  logic             step_q, step_rise;
  logic [15:0]      wait_cnt;
  logic             in_wait, timeout_hit;
  logic             retire, boundary;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  logic             mem_req, mem_we, ir_we, pc_we, rf_we;
  logic [1:0]       pc_src, wb_sel, wb_sel_op;

  assign step_rise   = bus.step & ~step_q;
  assign in_wait     = ((state == FETCH) || (state == MEM)) && !bus.mem_ack;
  assign timeout_hit = in_wait && (wait_cnt == 16'(TIMEOUT - 1));
  assign wb_sel_op   = (bus.opcode == OP_LOAD) ? 2'd1 :
                       ((bus.opcode == OP_JAL) || (bus.opcode == OP_JALR)) ? 2'd2 : 2'd0;

  always_comb begin
    state_nx   = state;
    oneshot_nx = oneshot;
    illegal_nx = illegal;
    bus_err_nx = bus_err;
    retire     = 1'b0;
    boundary   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    rf_we      = 1'b0;
    wb_sel     = 2'd0;
    case (state)
      HALT: begin
        // A step edge also wins when run_en is low, giving exactly one instruction.
        if (!illegal && !bus_err) begin
          if (bus.run_en) begin
            state_nx = FETCH;
          end else if (step_rise) begin
            state_nx   = FETCH;
            oneshot_nx = 1'b1;
          end
        end
      end
      FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_we    = 1'b1;
          pc_we    = 1'b1;
          state_nx = DECODE;
        end else if (timeout_hit) begin
          bus_err_nx = 1'b1;
          state_nx   = HALT;
        end
      end
      DECODE: begin
        case (bus.opcode)
          OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
          OP_BRANCH, OP_JAL, OP_JALR: state_nx = EXEC;
          OP_SYSTEM: begin
            retire   = 1'b1;
            state_nx = HALT;
          end
          default: begin
            illegal_nx = 1'b1;
            state_nx   = HALT;
          end
        endcase
      end
      EXEC: begin
        wb_sel = wb_sel_op;
        case (bus.opcode)
          OP_R, OP_I, OP_LUI, OP_AUIPC: state_nx = WB;
          OP_LOAD, OP_STORE:            state_nx = MEM;
          OP_BRANCH: begin
            pc_we    = bus.branch_taken;
            pc_src   = 2'd1;
            retire   = 1'b1;
            boundary = 1'b1;
          end
          OP_JAL: begin
            pc_we    = 1'b1;
            pc_src   = 2'd1;
            state_nx = WB;
          end
          OP_JALR: begin
            pc_we    = 1'b1;
            pc_src   = 2'd2;
            state_nx = WB;
          end
          default: begin
            illegal_nx = 1'b1;
            state_nx   = HALT;
          end
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = (bus.opcode == OP_STORE);
        wb_sel  = wb_sel_op;
        if (bus.mem_ack) begin
          if (bus.opcode == OP_STORE) begin
            retire   = 1'b1;
            boundary = 1'b1;
          end else begin
            state_nx = WB;
          end
        end else if (timeout_hit) begin
          bus_err_nx = 1'b1;
          state_nx   = HALT;
        end
      end
      WB: begin
        rf_we    = 1'b1;
        wb_sel   = wb_sel_op;
        retire   = 1'b1;
        boundary = 1'b1;
      end
      default: state_nx = HALT;
    endcase
    if (boundary) begin
      state_nx = (bus.run_en && !oneshot) ? FETCH : HALT;
    end
    if (state_nx == HALT) begin
      oneshot_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RESET_STATE;
      oneshot     <= 1'b0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
      step_q      <= 1'b0;
      wait_cnt    <= 16'd0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state   <= state_nx;
      oneshot <= oneshot_nx;
      illegal <= illegal_nx;
      bus_err <= bus_err_nx;
      step_q  <= bus.step;
      // Leaving FETCH/MEM always zeroes the counter, so each entry starts fresh.
      wait_cnt <= (in_wait && !timeout_hit) ? wait_cnt + 16'd1 : 16'd0;
      if (state != HALT) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (retire) begin
        instret_cnt <= instret_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.mem_req     = mem_req & ~rst;
  assign bus.mem_we      = mem_we & ~rst;
  assign bus.ir_we       = ir_we & ~rst;
  assign bus.pc_we       = pc_we & ~rst;
  assign bus.rf_we       = rf_we & ~rst;
  assign bus.pc_src      = pc_src & {2{~rst}};
  assign bus.wb_sel      = wb_sel & {2{~rst}};
  assign bus.halted      = (state == HALT);
  assign bus.illegal     = illegal;
  assign bus.bus_err     = bus_err;
  assign bus.state       = state;
  assign bus.cycle_cnt   = cycle_cnt;
  assign bus.instret_cnt = instret_cnt;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_seq.sv
// tb_multicycle_seq: directed per-cycle vector table plus hand sequences for reset, halt, step and timeout.
`default_nettype none
module tb_multicycle_seq;
  localparam int CNT_W = 32;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_ILL = 7'b1111111;
  localparam logic [1:0] X = 2'd3;  // "don't check" marker for pc_src / wb_sel

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_seq_if #(.CNT_W(CNT_W)) aif ();
  multicycle_seq_if #(.CNT_W(CNT_W)) bif ();

  multicycle_seq #(.CNT_W(CNT_W), .TIMEOUT(4), .START_HALTED(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(aif.master)
  );
  multicycle_seq #(.CNT_W(CNT_W), .TIMEOUT(255), .START_HALTED(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(bif.master)
  );

  // outs = {mem_req, mem_we, ir_we, pc_we, rf_we}
  typedef struct packed {
    logic       run;
    logic [6:0] op;
    logic       br;
    logic       ack;
    logic [2:0] st;
    logic [4:0] outs;
    logic [1:0] pcsrc;
    logic [1:0] wbsel;
  } vec_t;

  vec_t q[$];
  int tests = 0;
  int failed = 0;
  int m1, m2, m3, m4, m5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic run, input logic [6:0] op, input logic br, input logic ack,
                     input logic [2:0] st, input logic [4:0] outs, input logic [1:0] pcsrc,
                     input logic [1:0] wbsel);
    vec_t v;
    v.run = run; v.op = op; v.br = br; v.ack = ack;
    v.st = st; v.outs = outs; v.pcsrc = pcsrc; v.wbsel = wbsel;
    q.push_back(v);
  endtask

  task automatic fd(input logic [6:0] op);
    add(1'b1, op, 1'b0, 1'b1, 3'd1, 5'b10110, 2'd0, X);
    add(1'b1, op, 1'b0, 1'b1, 3'd2, 5'b00000, X, X);
  endtask

  // Entered at a negedge; each vector is one clock cycle.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      aif.run_en = q[i].run; aif.opcode = q[i].op;
      aif.branch_taken = q[i].br; aif.mem_ack = q[i].ack;
      #1;
      check($sformatf("vec%0d state/enables", i),
            {24'd0, aif.state, aif.mem_req, aif.mem_we, aif.ir_we, aif.pc_we, aif.rf_we},
            {24'd0, q[i].st, q[i].outs});
      if (q[i].pcsrc != X) check($sformatf("vec%0d pc_src", i), {30'd0, aif.pc_src}, {30'd0, q[i].pcsrc});
      if (q[i].wbsel != X) check($sformatf("vec%0d wb_sel", i), {30'd0, aif.wb_sel}, {30'd0, q[i].wbsel});
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aif.run_en = 1'b1; aif.step = 1'b0; aif.opcode = OP_R; aif.branch_taken = 1'b0; aif.mem_ack = 1'b1;
    bif.run_en = 1'b0; bif.step = 1'b0; bif.opcode = OP_R; bif.branch_taken = 1'b0; bif.mem_ack = 1'b1;

    for (int k = 0; k < 3; k++) begin
      fd(OP_R);
      add(1'b1, OP_R, 1'b0, 1'b1, 3'd3, 5'b00000, X, X);
      add(1'b1, OP_R, 1'b0, 1'b1, 3'd5, 5'b00001, X, 2'd0);
    end
    m1 = q.size();
    fd(OP_LD);
    add(1'b1, OP_LD, 1'b0, 1'b1, 3'd3, 5'b00000, X, X);
    for (int k = 0; k < 3; k++) add(1'b1, OP_LD, 1'b0, 1'b0, 3'd4, 5'b10000, X, X);
    add(1'b1, OP_LD, 1'b0, 1'b1, 3'd4, 5'b10000, X, X);
    add(1'b1, OP_LD, 1'b0, 1'b0, 3'd5, 5'b00001, X, 2'd1);
    add(1'b1, OP_ST, 1'b0, 1'b0, 3'd1, 5'b10000, X, X);
    fd(OP_ST);
    add(1'b1, OP_ST, 1'b0, 1'b0, 3'd3, 5'b00000, X, X);
    add(1'b1, OP_ST, 1'b0, 1'b0, 3'd4, 5'b11000, X, X);
    add(1'b1, OP_ST, 1'b0, 1'b1, 3'd4, 5'b11000, X, X);
    fd(OP_BR);
    add(1'b1, OP_BR, 1'b1, 1'b0, 3'd3, 5'b00010, 2'd1, X);
    fd(OP_BR);
    add(1'b1, OP_BR, 1'b0, 1'b0, 3'd3, 5'b00000, X, X);
    fd(OP_JAL);
    add(1'b1, OP_JAL, 1'b0, 1'b0, 3'd3, 5'b00010, 2'd1, X);
    add(1'b1, OP_JAL, 1'b0, 1'b0, 3'd5, 5'b00001, X, 2'd2);
    fd(OP_JR);
    add(1'b1, OP_JR, 1'b0, 1'b0, 3'd3, 5'b00010, 2'd2, X);
    add(1'b1, OP_JR, 1'b0, 1'b0, 3'd5, 5'b00001, X, 2'd2);
    fd(OP_LUI);
    add(1'b1, OP_LUI, 1'b0, 1'b0, 3'd3, 5'b00000, X, X);
    add(1'b0, OP_LUI, 1'b0, 1'b0, 3'd5, 5'b00001, X, 2'd0);
    add(1'b0, OP_R, 1'b0, 1'b1, 3'd0, 5'b00000, X, X);
    add(1'b0, OP_R, 1'b0, 1'b1, 3'd0, 5'b00000, X, X);
    m2 = q.size();
    add(1'b1, OP_R, 1'b0, 1'b1, 3'd0, 5'b00000, X, X);
    fd(OP_R);
    add(1'b1, OP_R, 1'b0, 1'b1, 3'd3, 5'b00000, X, X);
    add(1'b1, OP_R, 1'b0, 1'b1, 3'd5, 5'b00001, X, 2'd0);
    fd(OP_ILL);
    add(1'b1, OP_R, 1'b0, 1'b1, 3'd0, 5'b00000, X, X);
    add(1'b1, OP_R, 1'b0, 1'b1, 3'd0, 5'b00000, X, X);
    m3 = q.size();
    fd(OP_SYS);
    add(1'b1, OP_R, 1'b0, 1'b0, 3'd0, 5'b00000, X, X);
    for (int k = 0; k < 4; k++) add(1'b1, OP_R, 1'b0, 1'b0, 3'd1, 5'b10000, X, X);
    add(1'b1, OP_R, 1'b0, 1'b0, 3'd0, 5'b00000, X, X);
    add(1'b1, OP_R, 1'b0, 1'b1, 3'd0, 5'b00000, X, X);
    m4 = q.size();
    add(1'b1, OP_R, 1'b0, 1'b1, 3'd1, 5'b10110, 2'd0, X);
    add(1'b1, OP_R, 1'b0, 1'b0, 3'd2, 5'b00000, X, X);
    add(1'b1, OP_R, 1'b0, 1'b0, 3'd3, 5'b00000, X, X);
    m5 = q.size();

    // In reset: FETCH state but enables gated low.
    @(negedge clk); #1;
    check("reset state_a", {29'd0, aif.state}, 32'd1);
    check("reset mem_req/ir_we", {30'd0, aif.mem_req, aif.ir_we}, 32'd0);
    check("reset counters_a", aif.cycle_cnt | aif.instret_cnt, 32'd0);
    check("reset sticky_a", {30'd0, aif.illegal, aif.bus_err}, 32'd0);
    check("reset state_b", {29'd0, bif.state}, 32'd0);
    check("reset halted_b", {31'd0, bif.halted}, 32'd1);

    @(negedge clk); rst = 1'b0;
    run_vecs(0, m1);
    check("alu instret", aif.instret_cnt, 32'd3);
    check("alu cycles", aif.cycle_cnt, 32'd12);
    run_vecs(m1, m2);
    check("mix instret", aif.instret_cnt, 32'd10);
    check("mix cycles", aif.cycle_cnt, 32'd44);
    check("mix halted", {31'd0, aif.halted}, 32'd1);
    run_vecs(m2, m3);
    check("illegal flag", {31'd0, aif.illegal}, 32'd1);
    check("illegal instret", aif.instret_cnt, 32'd11);
    check("illegal cycles", aif.cycle_cnt, 32'd50);

    #3 rst = 1'b1; #1;
    check("rst clears illegal", {31'd0, aif.illegal}, 32'd0);
    check("rst async state", {29'd0, aif.state}, 32'd1);
    check("rst async mem_req", {31'd0, aif.mem_req}, 32'd0);
    check("rst async instret", aif.instret_cnt, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_vecs(m3, m4);
    check("timeout bus_err", {31'd0, aif.bus_err}, 32'd1);
    check("timeout illegal", {31'd0, aif.illegal}, 32'd0);
    check("system+timeout instret", aif.instret_cnt, 32'd1);
    check("timeout cycles", aif.cycle_cnt, 32'd6);
    check("timeout halted", {31'd0, aif.halted}, 32'd1);

    #3 rst = 1'b1; #1;
    check("rst clears bus_err", {31'd0, aif.bus_err}, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_vecs(m4, m5);
    #1 check("wb rf_we before rst", {31'd0, aif.rf_we}, 32'd1);
    #1 rst = 1'b1; #1;
    check("rst mid-WB rf_we", {31'd0, aif.rf_we}, 32'd0);
    check("rst mid-WB state", {29'd0, aif.state}, 32'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check("post-rst no retire", aif.instret_cnt, 32'd0);
    check("post-rst cycles", aif.cycle_cnt, 32'd1);
    check("post-rst waiting fetch", {29'd0, aif.state}, 32'd1);

    // Single step on the START_HALTED instance; step is held high as a level.
    begin
      logic [2:0] exp_b [8];
      exp_b = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0};
      @(negedge clk); bif.step = 1'b1;
      for (int k = 0; k < 8; k++) begin
        #1 check($sformatf("step state c%0d", k), {29'd0, bif.state}, {29'd0, exp_b[k]});
        @(negedge clk);
      end
    end
    check("step instret", bif.instret_cnt, 32'd1);
    check("step cycles", bif.cycle_cnt, 32'd4);
    check("step halted", {31'd0, bif.halted}, 32'd1);
    bif.step = 1'b0;
    @(negedge clk); bif.step = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("step2 instret", bif.instret_cnt, 32'd2);
    check("step2 cycles", bif.cycle_cnt, 32'd8);
    check("step2 state", {29'd0, bif.state}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
`default_nettype wire
